// File: rtl/target_gen_pkg.sv
// Shared types and constants for the target-number game controller.
package target_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_BLANK,
        S_PLAY,
        S_HIT,
        S_MISS,
        S_OVER
    } state_e;

    localparam int          NUM_W        = 8;
    localparam int          LIVES_W      = 3;
    localparam int          BLANK_CYCLES = 2;
    localparam logic [7:0]  LFSR_MASK    = 8'hB8;

    function automatic logic [NUM_W-1:0] lfsr_step(input logic [NUM_W-1:0] v);
        return {1'b0, v[NUM_W-1:1]} ^ (v[0] ? LFSR_MASK : 8'h00);
    endfunction

endpackage

// File: rtl/lfsr8_gen.sv
// Free-running 8-bit Galois LFSR; a zero seed is replaced so it never locks up.
module lfsr8_gen
    import target_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_W-1:0] seed,
    output logic [NUM_W-1:0] value
);

    logic [NUM_W-1:0] value_q;
    logic [NUM_W-1:0] value_d;

    always_comb begin
        value_d = lfsr_step(value_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= (seed == '0) ? 8'h01 : seed;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/target_generator.sv
// Round controller: draws a target, times the round, filters hits, keeps score and lives.
module target_generator
    import target_gen_pkg::*;
#(
    parameter int             TIMEOUT_TICKS = 10,
    parameter int             HOLD_CYCLES   = 4,
    parameter logic [7:0]     LFSR_SEED     = 8'hA5,
    parameter int             MAX_LIVES     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               tick,
    input  logic               is_equal,
    output logic [NUM_W-1:0]   number,
    output logic               playing,
    output logic [7:0]         time_left,
    output logic [7:0]         score,
    output logic [LIVES_W-1:0] lives,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               game_over
);

    state_e             state_q, state_d;
    logic [1:0]         blank_q, blank_d;
    logic [7:0]         hold_q, hold_d;
    logic [NUM_W-1:0]   number_q, number_d;
    logic [7:0]         time_left_q, time_left_d;
    logic [7:0]         score_q, score_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               playing_q, playing_d;
    logic               over_q, over_d;
    logic [NUM_W-1:0]   lfsr_val;

    lfsr8_gen u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .seed  (LFSR_SEED),
        .value (lfsr_val)
    );

    always_comb begin
        state_d     = state_q;
        blank_d     = blank_q;
        hold_d      = hold_q;
        number_d    = number_q;
        time_left_d = time_left_q;
        score_d     = score_q;
        lives_d     = lives_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d = S_DRAW;
                    score_d = '0;
                    lives_d = LIVES_W'(MAX_LIVES);
                end
            end
            S_DRAW: begin
                // stalling one cycle on a repeat guarantees a fresh target
                if (lfsr_val != number_q) begin
                    number_d    = lfsr_val;
                    time_left_d = 8'(TIMEOUT_TICKS);
                    hold_d      = '0;
                    blank_d     = 2'(BLANK_CYCLES - 1);
                    state_d     = S_BLANK;
                end
            end
            S_BLANK: begin
                if (blank_q == '0) begin
                    state_d = S_PLAY;
                end else begin
                    blank_d = blank_q - 2'd1;
                end
            end
            S_PLAY: begin
                hold_d = is_equal ? hold_q + 8'd1 : 8'd0;
                if (tick && time_left_q != '0) begin
                    time_left_d = time_left_q - 8'd1;
                end
                if (is_equal && hold_q == 8'(HOLD_CYCLES - 1)) begin
                    state_d = S_HIT;
                    hit_d   = 1'b1;
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                end else if (tick && time_left_q == 8'd1) begin
                    state_d = S_MISS;
                    miss_d  = 1'b1;
                    lives_d = lives_q - 3'd1;
                end
            end
            S_HIT: begin
                state_d = S_DRAW;
            end
            S_MISS: begin
                state_d = (lives_q == '0) ? S_OVER : S_DRAW;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        playing_d = (state_d == S_PLAY);
        over_d    = (state_d == S_OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            blank_q     <= '0;
            hold_q      <= '0;
            number_q    <= '0;
            time_left_q <= '0;
            score_q     <= '0;
            lives_q     <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            playing_q   <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            blank_q     <= blank_d;
            hold_q      <= hold_d;
            number_q    <= number_d;
            time_left_q <= time_left_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            playing_q   <= playing_d;
            over_q      <= over_d;
        end
    end

    assign number     = number_q;
    assign playing    = playing_q;
    assign time_left  = time_left_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign game_over  = over_q;

endmodule

// File: tb/tb_target_generator.sv
// Bench for target_generator: behavioural round model plus directed and random play.
module tb_target_generator;

    localparam int TO    = 10;
    localparam int HOLD  = 4;
    localparam int LIVES = 3;

    logic       clk;
    logic       rst;
    logic       start;
    logic       tick;
    logic       is_equal;
    logic [7:0] number;
    logic       playing;
    logic [7:0] time_left;
    logic [7:0] score;
    logic [2:0] lives;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       game_over;

    int total = 0;
    int bad   = 0;
    bit armed = 0;

    target_generator #(
        .TIMEOUT_TICKS (TO),
        .HOLD_CYCLES   (HOLD),
        .LFSR_SEED     (8'hA5),
        .MAX_LIVES     (LIVES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .tick       (tick),
        .is_equal   (is_equal),
        .number     (number),
        .playing    (playing),
        .time_left  (time_left),
        .score      (score),
        .lives      (lives),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase names and counters of the game rules.
    localparam int P_IDLE  = 0;
    localparam int P_DRAW  = 1;
    localparam int P_BLANK = 2;
    localparam int P_PLAY  = 3;
    localparam int P_HIT   = 4;
    localparam int P_MISS  = 5;
    localparam int P_OVER  = 6;

    int   ph;
    int   blank_left;
    int   streak;
    int   m_lfsr;
    int   m_num;
    int   m_tl;
    int   m_score;
    int   m_lives;
    bit   m_hit;
    bit   m_miss;

    function automatic int next_lfsr(input int v);
        int r;
        r = v >> 1;
        if ((v % 2) == 1) r = r ^ 'hB8;
        return r;
    endfunction

    always @(posedge clk) begin
        int nl;
        int old_tl;
        nl     = next_lfsr(m_lfsr);
        m_hit  = 0;
        m_miss = 0;
        if (rst) begin
            ph = P_IDLE; m_num = 0; m_tl = 0; m_score = 0; m_lives = 0;
            streak = 0; blank_left = 0;
            nl = 'hA5;
        end else if (ph == P_IDLE || ph == P_OVER) begin
            if (start) begin
                ph = P_DRAW; m_score = 0; m_lives = LIVES;
            end
        end else if (ph == P_DRAW) begin
            if (m_lfsr != m_num) begin
                m_num = m_lfsr; m_tl = TO; streak = 0;
                blank_left = 2; ph = P_BLANK;
            end
        end else if (ph == P_BLANK) begin
            blank_left--;
            if (blank_left == 0) ph = P_PLAY;
        end else if (ph == P_PLAY) begin
            old_tl = m_tl;
            streak = is_equal ? streak + 1 : 0;
            if (tick && m_tl > 0) m_tl--;
            if (streak >= HOLD) begin
                m_hit = 1; ph = P_HIT;
                if (m_score < 255) m_score++;
            end else if (tick && old_tl == 1) begin
                m_miss = 1; m_lives--; ph = P_MISS;
            end
        end else if (ph == P_HIT) begin
            ph = P_DRAW;
        end else if (ph == P_MISS) begin
            ph = (m_lives == 0) ? P_OVER : P_DRAW;
        end
        m_lfsr = nl;
    end

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process against the model on every cycle.
    always @(negedge clk) begin
        if (armed) begin
            cmp("number",     int'(number),     m_num);
            cmp("playing",    int'(playing),    int'(ph == P_PLAY));
            cmp("time_left",  int'(time_left),  m_tl);
            cmp("score",      int'(score),      m_score);
            cmp("lives",      int'(lives),      m_lives);
            cmp("hit_pulse",  int'(hit_pulse),  int'(m_hit));
            cmp("miss_pulse", int'(miss_pulse), int'(m_miss));
            cmp("game_over",  int'(game_over),  int'(ph == P_OVER));
        end
    end

    task automatic cyc(input bit r, input bit s, input bit t, input bit e);
        rst = r; start = s; tick = t; is_equal = e;
        @(negedge clk);
    endtask

    task automatic wait_play();
        int n;
        n = 0;
        while (!playing && n < 20) begin
            cyc(0, 0, 0, 0);
            n++;
        end
        if (!playing) begin
            total++; bad++;
            $display("FAIL wait_play: playing=%0b after %0d cycles, required 1", playing, n);
        end
    endtask

    initial begin
        m_lfsr = 0;
        ph = P_IDLE;
        rst = 1; start = 0; tick = 0; is_equal = 0;
        armed = 1;
        @(negedge clk);
        cyc(1, 0, 0, 0);
        cmp("rst_number", int'(number), 0);
        cmp("rst_lives", int'(lives), 0);
        cmp("rst_playing", int'(playing), 0);
        cmp("rst_over", int'(game_over), 0);

        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cmp("not_yet_playing", int'(playing), 0);
        cyc(0, 0, 0, 0);
        cmp("start_playing", int'(playing), 1);
        cmp("first_number", int'(number), 'hEA);
        cmp("first_tl", int'(time_left), 10);
        cmp("first_lives", int'(lives), 3);
        cmp("first_score", int'(score), 0);

        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        cmp("hold3_no_hit", int'(hit_pulse), 0);
        cyc(0, 0, 0, 1);
        cmp("hold4_hit", int'(hit_pulse), 1);
        cmp("hold4_score", int'(score), 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cmp("new_number_differs", int'(number != 8'hEA), 1);
        cmp("blank_not_playing", int'(playing), 0);
        wait_play();

        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        cmp("bounce_no_hit", int'(hit_pulse), 0);
        cyc(0, 0, 0, 1);
        cmp("bounce_hit", int'(hit_pulse), 1);
        cmp("bounce_score", int'(score), 2);
        wait_play();

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 9; k++) cyc(0, 0, 1, 0);
            cmp("tl_one", int'(time_left), 1);
            cyc(0, 0, 1, 0);
            cmp("miss_pulse", int'(miss_pulse), 1);
            cmp("miss_lives", int'(lives), 2 - r);
            if (r < 2) wait_play();
        end
        cyc(0, 0, 1, 0);
        cmp("over_flag", int'(game_over), 1);
        cmp("over_playing", int'(playing), 0);
        cyc(0, 1, 0, 0);
        cmp("restart_score", int'(score), 0);
        cmp("restart_lives", int'(lives), 3);
        wait_play();

        for (int k = 0; k < 9; k++) cyc(0, 0, 1, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 1);
        cmp("tie_hit", int'(hit_pulse), 1);
        cmp("tie_miss", int'(miss_pulse), 0);
        cmp("tie_lives", int'(lives), 3);
        wait_play();

        for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0);
        cmp("mid_tl5", int'(time_left), 5);
        cyc(1, 0, 0, 0);
        cmp("mid_rst_number", int'(number), 0);
        cmp("mid_rst_score", int'(score), 0);
        cmp("mid_rst_miss", int'(miss_pulse), 0);
        cyc(0, 0, 1, 0);
        cmp("idle_tick_tl", int'(time_left), 0);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 499) == 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) < 8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
